mod3_share_arbiter: RTL
=======================

# mod3_share_arbiter

Shares one serial divisible-by-3 residue engine between two word-level requesters. Each accepted word is fed MSB-first, one bit per clock, into the engine. The engine tracks remainder r ← (2r + bit) mod 3. Once the last bit is consumed, the block returns the remainder, a divisible flag and the requester ID through a valid/ready response port.

## Interface
- WIDTH, 8, bits per request word; legal range 1..32
- clk  in  1  rising-edge clock
- res  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a word
- req0_data  in  WIDTH  requester 0 word; bit WIDTH-1 is sent first
- req0_ready  out  1  requester 0 word accepted this cycle
- req1_valid  in  1  requester 1 has a word
- req1_data  in  WIDTH  requester 1 word
- req1_ready  out  1  requester 1 word accepted this cycle
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that owns the result
- rsp_rem  out  2  remainder mod 3 (0, 1 or 2)
- rsp_div3  out  1  1 when rsp_rem == 0
- busy  out  1  state != IDLE

## Operation
**States.**
- IDLE: wait for a requester.
- SHIFT: feed bits to the engine.
- DONE: hold the result.

**IDLE.**
- reqN_ready = (state == IDLE) && grant == N. reqN_ready is a combinational function of the valids and the priority pointer.
- When grant_valid is high, the data of the granted requester is captured into the shift register.
- The engine residue is cleared to 0, bit counter ← WIDTH-1, owner ← grant.
- Next state is SHIFT.

**SHIFT.**
- Each cycle the engine consumes shreg[WIDTH-1], then shreg shifts left.
- When the counter reaches 0, the next state is DONE. Otherwise the counter decrements.

**DONE.**
- rsp_valid = 1. rsp_id, rsp_rem and rsp_div3 are held stable.
- When rsp_ready is high, the next state is IDLE.

**Grant.**
- Only one requester valid: that requester is granted.
- Both valid: priority pointer decides (see Configuration).
- Pointer ← owner on each acceptance.

**Valid behaviour.**
- A requester may drop valid before it is granted; this has no side effect.
- reqN_data is not sampled after acceptance.
- Valids that arrive while the block is busy are ignored until IDLE. ready stays 0 during that time.

**Reset (res = 0).**
- Outputs: all ready = 0, rsp_valid = 0, rsp_id = 0, rsp_rem = 0, rsp_div3 = 0, busy = 0.
- Internal: state = IDLE, pointer = 1, so requester 0 wins the first tie.

**Reset mid-operation.** Any in-flight word is discarded and no response is produced.

**Arithmetic.**
- The residue is a 2-bit register that only ever holds 0, 1 or 2.
- Next residue:
  - r = 0: bit 0 → 0, bit 1 → 1
  - r = 1: bit 0 → 2, bit 1 → 0
  - r = 2: bit 0 → 1, bit 1 → 2
- An all-zero word gives rem = 0 and div3 = 1.

## Timing
- Acceptance edge E0: handshake reqN_valid && reqN_ready.
- Shift edges E1..E_WIDTH each consume one bit.
- rsp_valid is high from E_WIDTH, i.e. WIDTH cycles after E0.
- Edge where rsp_valid && rsp_ready: state → IDLE. rsp_valid deasserts after that edge.
- The earliest next acceptance is the following edge.
- Minimum period per word is WIDTH+2 cycles.
- rsp_ready held low stalls in DONE indefinitely; no result is lost.
- WIDTH = 1: a single shift edge, and rsp_valid is high one cycle after acceptance.

## Configuration
- MOD3_ARB_RR_EN defined: round-robin. On a tie, grant the requester that is not the pointer.
- MOD3_ARB_RR_EN undefined:
  - Fixed priority: requester 0 always wins a tie.
  - The pointer is not implemented.
  - Requester 1 can starve under continuous requester-0 traffic.

## Structure
- Shared package mod3_arb_pkg holds:
  - state encodings IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10
  - residue constants R0 = 2'b00, R1 = 2'b01, R2 = 2'b10
- One sub-module, mod3_serial_engine, holds the residue register.
  - Inputs: clk, res, clr, en, bit_in. Output: rem.
  - With clr = 1 the residue is forced to R0.
  - With en = 1 the residue applies the next-residue rule above.
- The arbiter, counter, shift register and response registers live in the top module.

## Test plan
- WIDTH = 8, req0 sends 0x06 with rsp_ready = 1 → after 8 cycles: rsp_valid, rsp_id = 0, rsp_rem = 0, rsp_div3 = 1.
- WIDTH = 8, req1 sends 0xFF, 0x07, 0x05 in sequence → rem 0, 1, 2 respectively; div3 = 1, 0, 0; each result 8 cycles after its acceptance.
- Both valid continuously, 4 words each:
  - RR build: ids alternate 0, 1, 0, 1…
  - Fixed-priority build: all four id 0 results come first.
- rsp_ready held low 5 cycles in DONE → rsp_valid and the data stay stable. No reqN_ready is asserted until 1 cycle after the rsp handshake.
- Assert res = 0 at the 3rd shift cycle of 0x09, then release → no rsp_valid. busy = 0. The next word 0x0C gives rem 0 with correct timing.
- All-zero word 0x00 → rem 0, div3 = 1.

Source files
------------

// File: rtl/mod3_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mod3_arb_pkg
// Shared definitions for the mod-3 share arbiter:
//   - state_e : controller states (IDLE / SHIFT / DONE)
//   - R0..R2  : residue encodings held by the serial engine
//   - mod3_next() : one step of the MSB-first residue recurrence
//                   r <- (2r + bit) mod 3
// -----------------------------------------------------------------------------
package mod3_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    localparam logic [1:0] R0 = 2'b00;
    localparam logic [1:0] R1 = 2'b01;
    localparam logic [1:0] R2 = 2'b10;

    // Residue step; the unused encoding 2'b11 recovers to R0.
    function automatic logic [1:0] mod3_next(input logic [1:0] r, input logic b);
        logic [1:0] n;
        case (r)
            R0:      n = b ? R1 : R0;
            R1:      n = b ? R0 : R2;
            R2:      n = b ? R2 : R1;
            default: n = R0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mod3_share_arbiter_engine.sv
// -----------------------------------------------------------------------------
// mod3_serial_engine
// Serial divisible-by-3 residue tracker, one bit per clock, MSB first.
// Ports:
//   clk    in   rising-edge clock
//   res    in   asynchronous active-low reset
//   clr    in   force residue to R0 (has priority over en)
//   en     in   consume bit_in this cycle
//   bit_in in   next data bit
//   rem    out  current residue (R0, R1 or R2)
// -----------------------------------------------------------------------------
module mod3_serial_engine
    import mod3_arb_pkg::*;
(
    input  logic       clk,
    input  logic       res,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [1:0] rem
);

    logic [1:0] rem_q;
    logic [1:0] rem_d;

    // Next residue: clear, step, or hold.
    always_comb begin
        rem_d = rem_q;
        if (clr) begin
            rem_d = R0;
        end else if (en) begin
            rem_d = mod3_next(rem_q, bit_in);
        end else begin
            rem_d = rem_q;
        end
    end

    // Residue register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rem_q <= R0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem = rem_q;

endmodule

// File: rtl/mod3_share_arbiter.sv
// -----------------------------------------------------------------------------
// mod3_share_arbiter
// Shares one serial mod-3 residue engine between two word requesters.
// An accepted word is shifted MSB-first into the engine; once all WIDTH bits
// are consumed the remainder, a divisible-by-3 flag and the owner ID are held
// on a valid/ready response port.
//
// Build option: define MOD3_ARB_RR_EN for round-robin tie breaking (pointer
// register present). Without it, requester 0 always wins a tie.
//
// Ports:
//   clk, res               clock, asynchronous active-low reset
//   req0_valid/data/ready  requester 0 (ready is combinational grant)
//   req1_valid/data/ready  requester 1
//   rsp_valid, rsp_ready   result handshake
//   rsp_id, rsp_rem, rsp_div3  result owner, remainder, divisible flag
//   busy                   controller not in IDLE
// -----------------------------------------------------------------------------
module mod3_share_arbiter
    import mod3_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [1:0]       rsp_rem,
    output logic             rsp_div3,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q,    state_d;
    logic [WIDTH-1:0]   shreg_q,    shreg_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               owner_q,    owner_d;
    logic               rsp_id_q,   rsp_id_d;
    logic [1:0]         rsp_rem_q,  rsp_rem_d;
    logic               rsp_div3_q, rsp_div3_d;
`ifdef MOD3_ARB_RR_EN
    logic               ptr_q,      ptr_d;
`endif

    logic               grant_valid_s;
    logic               grant_s;
    logic               accept_s;
    logic               eng_clr_s;
    logic               eng_en_s;
    logic [1:0]         eng_rem_s;
    logic [1:0]         fin_rem_s;

    // Requester selection; ready is withheld while in reset.
    always_comb begin
        grant_valid_s = req0_valid | req1_valid;
        grant_s       = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef MOD3_ARB_RR_EN
            grant_s = ~ptr_q;
`else
            grant_s = 1'b0;
`endif
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        accept_s   = res && (state_q == IDLE) && grant_valid_s;
        req0_ready = accept_s && !grant_s;
        req1_ready = accept_s && grant_s;
    end

    // Controller next state, datapath updates and engine control.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        rsp_id_d   = rsp_id_q;
        rsp_rem_d  = rsp_rem_q;
        rsp_div3_d = rsp_div3_q;
`ifdef MOD3_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        eng_clr_s  = 1'b0;
        eng_en_s   = 1'b0;
        // Residue after the bit being consumed this cycle; captured on the last bit.
        fin_rem_s  = mod3_next(eng_rem_s, shreg_q[WIDTH-1]);
        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    shreg_d   = grant_s ? req1_data : req0_data;
                    cnt_d     = CNT_W'(WIDTH - 1);
                    owner_d   = grant_s;
                    eng_clr_s = 1'b1;
`ifdef MOD3_ARB_RR_EN
                    ptr_d     = grant_s;
`endif
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                eng_en_s = 1'b1;
                shreg_d  = shreg_q << 1;
                if (cnt_q == CNT_W'(0)) begin
                    rsp_id_d   = owner_q;
                    rsp_rem_d  = fin_rem_s;
                    rsp_div3_d = (fin_rem_s == R0);
                    state_d    = DONE;
                end else begin
                    cnt_d      = cnt_q - CNT_W'(1);
                    state_d    = SHIFT;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and response registers.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_rem_q  <= R0;
            rsp_div3_q <= 1'b0;
`ifdef MOD3_ARB_RR_EN
            ptr_q      <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            rsp_id_q   <= rsp_id_d;
            rsp_rem_q  <= rsp_rem_d;
            rsp_div3_q <= rsp_div3_d;
`ifdef MOD3_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    mod3_serial_engine u_engine (
        .clk    (clk),
        .res    (res),
        .clr    (eng_clr_s),
        .en     (eng_en_s),
        .bit_in (shreg_q[WIDTH-1]),
        .rem    (eng_rem_s)
    );

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_rem   = rsp_rem_q;
    assign rsp_div3  = rsp_div3_q;

endmodule
